rr_packet_dispatcher: RTL and testbench
=======================================

Name: rr_packet_dispatcher

Overview:
- Splits one valid/ready packet stream into WIDTH output channels.
- Whole packets go to the next enabled, ready channel in round-robin order.
- Sits in front of parallel processing or readout lanes, for example per-FIFO TDC or hit-data lanes.
- This is the distributing counterpart of a round-robin merge arbiter: the block locks onto a channel for a full packet, then rotates its priority base.

Parameters:
- WIDTH, 4, number of output channels (≥2).
- DATA_WIDTH, 32, payload width.
- CNT_WIDTH, 16, width of the dispatched-packet counter.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST_N  input  1  synchronous active-low reset.
- CH_EN  input  WIDTH  per-channel enable mask; sampled only at packet selection.
- S_DATA  input  DATA_WIDTH  input beat payload.
- S_VALID  input  1  input beat valid.
- S_LAST  input  1  last beat of the packet.
- S_READY  output  1  input beat accepted when S_VALID&S_READY.
- M_DATA  output  DATA_WIDTH  registered payload, shared by all channels.
- M_LAST  output  1  registered last flag, shared.
- M_VALID  output  WIDTH  one-hot valid, set only for the selected channel.
- M_READY  input  WIDTH  per-channel ready.
- BUSY  output  1  high while a packet is locked to a channel.
- PKT_CNT  output  CNT_WIDTH  number of packets fully dispatched; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (RST_N=0 at a CLK edge): state=IDLE, base=one-hot bit 0, sel=0, out_vld=0, S_READY=0, M_VALID=0, M_DATA=0, M_LAST=0, BUSY=0, PKT_CNT=0. Reset mid-packet discards the held beat and the rest of the packet; the source must restart.
- States: IDLE, FWD, DRAIN.
- IDLE:
  - S_READY=0.
  - cand = M_READY & CH_EN.
  - If S_VALID and cand≠0: sel <= the first set bit of cand, searching from the base index upward with wrap-around; go to FWD.
  - Otherwise stay in IDLE.
- FWD:
  - BUSY=1.
  - S_READY = !out_vld | M_READY[sel] (combinational).
  - On an input handshake: M_DATA/M_LAST <= S_DATA/S_LAST and out_vld <= 1.
  - Else on an output handshake: out_vld <= 0.
  - If the accepted beat has S_LAST=1: go to DRAIN.
  - Throughput is 1 beat/cycle while M_READY[sel] stays high.
- DRAIN:
  - S_READY=0.
  - When out_vld & M_READY[sel]: out_vld <= 0, base <= sel rotated left by 1 (bit WIDTH-1 wraps to bit 0), PKT_CNT <= PKT_CNT+1, sel <= 0, go to IDLE.
- M_VALID = {WIDTH{out_vld}} & sel. M_DATA and M_LAST hold their value while M_VALID is high and M_READY[sel] is low.
- Latency:
  - A first beat present in IDLE is accepted 1 cycle after selection.
  - Each beat appears on M_* 1 cycle after its input handshake.
  - Inter-packet gap: S_READY is low for ≥2 cycles after a LAST beat is accepted (drain + select).
- Single-beat packets (S_VALID with S_LAST on the first beat) are legal: the FWD→DRAIN path is taken in one beat.
- CH_EN or M_READY of other channels changing mid-packet: no effect. A locked channel dropping M_READY only stalls the stream.
- Locked-channel backpressure: if M_READY[sel] is low in FWD with out_vld=1, then S_READY=0 and no data is lost.
- CH_EN=0: the block stays in IDLE indefinitely with S_READY=0.
- Selection is at most WIDTH-1 positions from base. The channel that just finished has lowest priority for the next packet.

Decomposition:
- No shared package needed. State encoding is module-local localparams (IDLE=2'd0, FWD=2'd1, DRAIN=2'd2).
- One natural combinational sub-module: rr_pick (WIDTH param; inputs req and one-hot base; output one-hot first-set bit from base with wrap-around). It is instantiated once for the selection.

Test Plan:
- Reset, WIDTH=4, all CH_EN=1, all M_READY=1 → all outputs zero. A first 3-beat packet (0xA0,0xA1,0xA2) appears on channel 0; the next packets go to channels 1, 2, 3, then back to 0; PKT_CNT=5 after 5 packets.
- CH_EN=4'b1010, 4 packets → channel order 1,3,1,3. M_VALID[0] and M_VALID[2] never assert.
- Mid-packet, drop M_READY[sel] for 3 cycles → S_READY=0 and M_DATA held stable for those 3 cycles. No beat is lost or duplicated; scoreboard the sequence 0x10..0x17.
- Single-beat packets back-to-back with continuous S_VALID → each goes to the next channel. S_READY low exactly 2 cycles between accepts when M_READY stays high.
- M_READY=4'b0000 with S_VALID=1 for 10 cycles → S_READY=0 and BUSY=0 throughout. Raise M_READY[2] → the packet goes to channel 2 and base becomes 4'b1000.
- Assert RST_N=0 for 1 cycle during beat 2 of a 5-beat packet → next cycle all outputs are at reset values. A new packet is dispatched to channel 0.

Source files
------------

// File: rtl/rr_packet_dispatcher_pick.sv
// Purpose: one-hot round-robin pick, first set req bit at or above base, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt is zero only when req is zero.
//
// Ports:
//   req  - request mask, one bit per channel
//   base - one-hot priority base; the search starts at this bit
//   gnt  - one-hot grant, or zero when no request is set
module rr_pick #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] gnt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] upper_gnt;
    logic [WIDTH-1:0] lower_gnt;

    // base-1 covers every bit below base; masking it off leaves the requests
    // at or above the base. If none remain, the search wraps to bit 0.
    assign upper     = req & ~(base - ONE);
    assign upper_gnt = upper & (~upper + ONE);
    assign lower_gnt = req & (~req + ONE);
    assign gnt       = (|upper) ? upper_gnt : lower_gnt;

endmodule

// File: rtl/rr_packet_dispatcher.sv
// Purpose: distributes whole packets of one valid/ready stream over WIDTH channels, round-robin.
// Latency: 1 cycle per beat; first beat accepted 1 cycle after selection; >=2 dead cycles per packet.
// Backpressure: only the locked channel's M_READY stalls S_READY; other channels are ignored mid-packet.
//
// Ports:
//   CLK, RST_N         - clock and synchronous active-low reset
//   CH_EN              - per-channel enable, looked at only when picking a channel
//   S_DATA/S_VALID/S_LAST/S_READY - input beat stream
//   M_DATA/M_LAST      - registered payload shared by all channels
//   M_VALID/M_READY    - one-hot valid and per-channel ready
//   BUSY               - a packet is locked to a channel
//   PKT_CNT            - packets fully delivered, wrapping
module rr_packet_dispatcher #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WIDTH-1:0]      CH_EN,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_VALID,
    input  logic                  S_LAST,
    output logic                  S_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_LAST,
    output logic [WIDTH-1:0]      M_VALID,
    input  logic [WIDTH-1:0]      M_READY,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  PKT_CNT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FWD   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] pick;
    logic             out_vld;
    logic             sel_rdy;
    logic             in_hs;
    logic             out_hs;
    logic             start;

    // A channel is a candidate only if it is both enabled and ready right now.
    assign cand    = M_READY & CH_EN;
    assign start   = S_VALID & (|cand);
    assign sel_rdy = |(M_READY & sel);
    assign out_hs  = out_vld & sel_rdy;
    assign in_hs   = S_VALID & S_READY;

    rr_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req  (cand),
        .base (base),
        .gnt  (pick)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)           state_nxt = FWD;
            FWD:     if (in_hs && S_LAST) state_nxt = DRAIN;
            DRAIN:   if (out_hs)          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Output logic: the input is open only while forwarding, and then only
    // if the output register is empty or being emptied this cycle.
    always_comb begin
        S_READY = 1'b0;
        BUSY    = 1'b0;
        case (state)
            FWD: begin
                S_READY = !out_vld || sel_rdy;
                BUSY    = 1'b1;
            end
            DRAIN: begin
                BUSY    = 1'b1;
            end
            default: begin
                S_READY = 1'b0;
                BUSY    = 1'b0;
            end
        endcase
    end

    // Datapath, channel lock and priority base
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            base    <= WIDTH'(1);
            sel     <= '0;
            out_vld <= 1'b0;
            M_DATA  <= '0;
            M_LAST  <= 1'b0;
            PKT_CNT <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel <= pick;
                    end
                end
                FWD: begin
                    if (in_hs) begin
                        M_DATA  <= S_DATA;
                        M_LAST  <= S_LAST;
                        out_vld <= 1'b1;
                    end else if (out_hs) begin
                        out_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        out_vld <= 1'b0;
                        // The channel just served becomes the lowest priority.
                        base    <= {sel[WIDTH-2:0], sel[WIDTH-1]};
                        PKT_CNT <= PKT_CNT + CNT_WIDTH'(1);
                        sel     <= '0;
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign M_VALID = {WIDTH{out_vld}} & sel;

endmodule

// File: tb/tb_rr_packet_dispatcher.sv
module tb_rr_packet_dispatcher;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  ch_en;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [W-1:0]  m_valid;
    logic [W-1:0]  m_ready;
    logic          busy;
    logic [CW-1:0] pkt_cnt;

    always #5 clk = ~clk;

    rr_packet_dispatcher #(
        .WIDTH      (W),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .CH_EN   (ch_en),
        .S_DATA  (s_data),
        .S_VALID (s_valid),
        .S_LAST  (s_last),
        .S_READY (s_ready),
        .M_DATA  (m_data),
        .M_LAST  (m_last),
        .M_VALID (m_valid),
        .M_READY (m_ready),
        .BUSY    (busy),
        .PKT_CNT (pkt_cnt)
    );

    typedef struct packed {
        logic [7:0]  ch;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        obs_q[$];
    int           acc_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           mbase = 0;
    int           mcnt = 0;
    bit           auto_rdy = 1'b0;
    logic [W-1:0] vld_seen = '0;
    logic [W-1:0] prev_stall = '0;
    logic [31:0]  prev_data = '0;
    logic         prev_last = 1'b0;
    int           mon_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first candidate channel searching upward from the model base.
    function automatic int model_pick(input logic [W-1:0] cand);
        for (int k = 0; k < W; k++) begin
            if (cand[(mbase + k) % W]) return (mbase + k) % W;
        end
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output/input monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            vld_seen = vld_seen | m_valid;
            if (prev_stall != '0) begin
                chk("hold_vld", m_valid, prev_stall);
                chk("hold_dat", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (|(m_valid & m_ready)) begin
                chk("onehot", $onehot(m_valid), 1);
                mon_idx = 0;
                for (int i = 0; i < W; i++) if (m_valid[i]) mon_idx = i;
                obs_q.push_back('{ch: 8'(mon_idx), d: m_data, l: m_last});
            end
            if (s_valid && s_ready) acc_q.push_back(cyc);
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_rdy) begin
            if ((|m_valid) && $urandom_range(0, 1) == 1) m_ready = W'($urandom);
            else m_ready = '1;
        end
    endtask

    task automatic put_beat(input logic [31:0] d, input logic l);
        int t = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 300) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk("s_ready_accept", s_ready, 1);
        tick();
    endtask

    task automatic send_pkt(input int n, input logic [31:0] d0, input bit seq);
        logic [W-1:0] cand;
        logic [31:0]  d;
        int           ch;
        cand  = ch_en & (auto_rdy ? {W{1'b1}} : m_ready);
        ch    = model_pick(cand);
        mbase = (ch + 1) % W;
        mcnt++;
        for (int i = 0; i < n; i++) begin
            d = seq ? d0 + 32'(i) : $urandom;
            exp_q.push_back('{ch: 8'(ch), d: d, l: (i == n - 1)});
            put_beat(d, i == n - 1);
        end
    endtask

    task automatic check_out(input string tag);
        int    t = 0;
        beat_t e;
        beat_t o;
        while (obs_q.size() < exp_q.size() && t < 500) begin
            tick();
            t++;
        end
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_ch"}, o.ch, e.ch);
            chk({tag, "_data"}, o.d, e.d);
            chk({tag, "_last"}, o.l, e.l);
        end
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        chk({tag, "_pkt_cnt"}, pkt_cnt, CW'(mcnt));
    endtask

    initial begin
        logic [31:0] held;
        int          t;

        // Reset state
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        ch_en   = '1;
        m_ready = '1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Rotation over all channels: 0,1,2,3,0
        send_pkt(3, 32'hA0, 1);
        for (int i = 0; i < 4; i++) send_pkt(2, 32'hC0 + 32'(16 * i), 1);
        s_valid = 1'b0;
        check_out("rot");

        // Only channels 1 and 3 enabled
        vld_seen = '0;
        ch_en    = 4'b1010;
        for (int i = 0; i < 4; i++) send_pkt(i + 1, 32'hD0 + 32'(16 * i), 1);
        s_valid = 1'b0;
        check_out("mask");
        chk("mask_vld_0_2", vld_seen & 4'b0101, 0);
        ch_en = '1;

        // Locked-channel stall for 3 cycles mid-packet
        fork
            send_pkt(8, 32'h10, 1);
            begin
                t = 0;
                while (!(m_valid != '0 && m_data == 32'h12) && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("stall_reach", m_data, 32'h12);
                m_ready = '0;
                held    = m_data;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_s_ready", s_ready, 0);
                    chk("stall_m_data", m_data, held);
                    @(posedge clk);
                    #1;
                end
                m_ready = '1;
            end
        join
        s_valid = 1'b0;
        check_out("stall");

        // Back-to-back single-beat packets, gap of exactly 2 dead cycles
        acc_q.delete();
        for (int i = 0; i < 4; i++) send_pkt(1, 32'hB0 + 32'(i), 1);
        s_valid = 1'b0;
        check_out("single");
        chk("single_accepts", acc_q.size(), 4);
        for (int i = 1; i < 4 && i < acc_q.size(); i++) chk("single_gap", acc_q[i] - acc_q[i-1], 3);

        // No ready channel: wait in idle, then only channel 2 comes ready
        m_ready = '0;
        s_valid = 1'b1;
        s_data  = 32'h70;
        s_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("noready_s_ready", s_ready, 0);
            chk("noready_busy", busy, 0);
            tick();
        end
        m_ready = 4'b0100;
        send_pkt(1, 32'h70, 1);
        s_valid = 1'b0;
        check_out("ch2");
        m_ready = '1;
        send_pkt(1, 32'h71, 1);
        send_pkt(1, 32'h7F, 1);
        s_valid = 1'b0;
        check_out("after_ch2");

        // Reset in the middle of a packet
        put_beat(32'h50, 1'b0);
        put_beat(32'h51, 1'b0);
        s_data = 32'h52;
        rst_n  = 1'b0;
        tick();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_last", m_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pkt_cnt", pkt_cnt, 0);
        exp_q.delete();
        obs_q.delete();
        mbase = 0;
        mcnt  = 0;
        tick();
        send_pkt(3, 32'h60, 1);
        s_valid = 1'b0;
        check_out("post_rst");

        // Random packets, random enables, random stalls while data is held
        auto_rdy = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ch_en = W'($urandom_range(1, 15));
            send_pkt($urandom_range(1, 6), 32'h0, 0);
        end
        s_valid = 1'b0;
        check_out("rand");
        auto_rdy = 1'b0;
        m_ready  = '1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
